dwt_2d_1level: RTL and testbench

//   Self-contained one-level 2-D integer Haar (S-transform) DWT engine. After reset it reads an

---
 rtl/dwt_2d_1level_pkg.sv | 20 ++
 rtl/dwt_2d_1level_haar_lift_pair.sv | 20 ++
 rtl/dwt_2d_1level.sv | 133 +++++++++++++
 tb/tb_dwt_2d_1level.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dwt_2d_1level_pkg.sv
// Shared types and default geometry for the one-level 2-D Haar (S-transform) engine.
package dwt_2d_1level_pkg;

  localparam int unsigned ROWS_DEF  = 8;
  localparam int unsigned COLS_DEF  = 8;
  localparam int unsigned PIX_W_DEF = 8;

  // Coefficient growth over the pixel width after each dimension.
  localparam int unsigned D1_EXT = 1;
  localparam int unsigned D2_EXT = 2;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL_L,
    COL_H,
    DONE
  } dwt_state_e;

endpackage

// File: rtl/dwt_2d_1level_haar_lift_pair.sv
// Integer Haar lifting on one pair: high = b - a, low = a + floor(high / 2).
module haar_lift_pair
  import dwt_2d_1level_pkg::*;
#(
  parameter int unsigned IN_W = PIX_W_DEF + D2_EXT
) (
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  output logic [IN_W-1:0] low,
  output logic [IN_W-1:0] high
);

  logic signed [IN_W-1:0] high_s;

  // Arithmetic shift gives floor division for negative differences.
  assign high_s = $signed(b) - $signed(a);
  assign high   = high_s;
  assign low    = $signed(a) + (high_s >>> 1);

endmodule

// File: rtl/dwt_2d_1level.sv
// One-level 2-D integer Haar DWT over an internal image ROM: row pass, then column passes on L and H halves.
module dwt_2d_1level
  import dwt_2d_1level_pkg::*;
#(
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned COLS  = COLS_DEF,
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic d1_over_o,
  output logic d2_low_over_o,
  output logic d2_high_over_o
);

  localparam int unsigned D1_W = PIX_W + D1_EXT;
  localparam int unsigned D2_W = PIX_W + D2_EXT;
  localparam int unsigned R_W  = $clog2(ROWS);
  localparam int unsigned C_W  = $clog2(COLS);

  localparam logic [C_W-1:0] C_HALF  = C_W'(COLS / 2);
  localparam logic [C_W-1:0] C_LAST  = C_W'(COLS / 2 - 1);
  localparam logic [R_W-1:0] R_HALF  = R_W'(ROWS / 2);
  localparam logic [R_W-1:0] R_LAST  = R_W'(ROWS - 1);
  localparam logic [R_W-1:0] RH_LAST = R_W'(ROWS / 2 - 1);

  dwt_state_e      state;
  logic [R_W-1:0]  cnt_r;
  logic [C_W-1:0]  cnt_c;

  logic [PIX_W-1:0]       pix_rom [ROWS][COLS];
  logic signed [D1_W-1:0] coef_d1 [ROWS][COLS];
  logic signed [D2_W-1:0] coef_d2 [ROWS][COLS];

  logic [R_W-1:0]  rd_r0, rd_r1;
  logic [C_W-1:0]  pc0, pc1, col_sel;
  logic [D2_W-1:0] op_a, op_b, lift_l, lift_h;

  // Constant image ROM.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_rom_r
    for (genvar gc = 0; gc < COLS; gc++) begin : g_rom_c
      assign pix_rom[gr][gc] = PIX_W'(gr * 16 + gc * 2);
    end
  end

  // Operand selection for the shared lifting unit.
  always_comb begin
    rd_r0   = cnt_r << 1;
    rd_r1   = (cnt_r << 1) | R_W'(1);
    pc0     = cnt_c << 1;
    pc1     = (cnt_c << 1) | C_W'(1);
    col_sel = (state == COL_H) ? cnt_c + C_HALF : cnt_c;
    op_a    = D2_W'(coef_d1[rd_r0][col_sel]);
    op_b    = D2_W'(coef_d1[rd_r1][col_sel]);
    if (state == ROW) begin
      op_a = D2_W'(pix_rom[cnt_r][pc0]);
      op_b = D2_W'(pix_rom[cnt_r][pc1]);
    end
  end

  haar_lift_pair #(.IN_W(D2_W)) u_lift (
    .a    (op_a),
    .b    (op_b),
    .low  (lift_l),
    .high (lift_h)
  );

  // Coefficient storage: L into the low quadrant, H into the high quadrant.
  always_ff @(posedge sys_clk) begin
    case (state)
      ROW: begin
        coef_d1[cnt_r][cnt_c]          <= D1_W'(lift_l);
        coef_d1[cnt_r][cnt_c + C_HALF] <= D1_W'(lift_h);
      end
      COL_L, COL_H: begin
        coef_d2[cnt_r][col_sel]          <= lift_l;
        coef_d2[cnt_r + R_HALF][col_sel] <= lift_h;
      end
      default: ;
    endcase
  end

  // Phase sequencing; each flag rises on the edge writing that phase's last pair.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state          <= IDLE;
      cnt_r          <= '0;
      cnt_c          <= '0;
      d1_over_o      <= 1'b0;
      d2_low_over_o  <= 1'b0;
      d2_high_over_o <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= ROW;
        ROW: begin
          if (cnt_c == C_LAST) begin
            cnt_c <= '0;
            if (cnt_r == R_LAST) begin
              cnt_r     <= '0;
              state     <= COL_L;
              d1_over_o <= 1'b1;
            end else begin
              cnt_r <= cnt_r + R_W'(1);
            end
          end else begin
            cnt_c <= cnt_c + C_W'(1);
          end
        end
        COL_L, COL_H: begin
          if (cnt_c == C_LAST) begin
            cnt_c <= '0;
            if (cnt_r == RH_LAST) begin
              cnt_r <= '0;
              if (state == COL_L) begin
                state         <= COL_H;
                d2_low_over_o <= 1'b1;
              end else begin
                state          <= DONE;
                d2_high_over_o <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r + R_W'(1);
            end
          end else begin
            cnt_c <= cnt_c + C_W'(1);
          end
        end
        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_dwt_2d_1level.sv
// Self-checking bench: flag timing, coefficient arrays against an arithmetic model, aborts, pair-op unit.
module tb_dwt_2d_1level;
  import dwt_2d_1level_pkg::*;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int PIX_W = 8;
  localparam int PW    = PIX_W + 2;

  logic sys_clk, sys_rst;
  logic d1_over_o, d2_low_over_o, d2_high_over_o;
  logic [PW-1:0] pa, pb, pl, ph;

  int checks = 0;
  int errors = 0;
  int exp_d1 [ROWS][COLS];
  int exp_d2 [ROWS][COLS];

  dwt_2d_1level dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .d1_over_o      (d1_over_o),
    .d2_low_over_o  (d2_low_over_o),
    .d2_high_over_o (d2_high_over_o)
  );

  haar_lift_pair #(.IN_W(PW)) u_pair (
    .a    (pa),
    .b    (pb),
    .low  (pl),
    .high (ph)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_half(input int v);
    return (v >= 0) ? v / 2 : -((-v + 1) / 2);
  endfunction

  function automatic int pix(input int r, input int c);
    return (r * 16 + c * 2) % (1 << PIX_W);
  endfunction

  // Expected transform from the pair rule applied to whole rows then whole columns.
  task automatic build_model();
    int a, b, h;
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < COLS / 2; j++) begin
        a = pix(r, 2 * j);
        b = pix(r, 2 * j + 1);
        h = b - a;
        exp_d1[r][j]          = a + floor_half(h);
        exp_d1[r][COLS/2 + j] = h;
      end
    for (int i = 0; i < ROWS / 2; i++)
      for (int c = 0; c < COLS; c++) begin
        a = exp_d1[2 * i][c];
        b = exp_d1[2 * i + 1][c];
        h = b - a;
        exp_d2[i][c]          = a + floor_half(h);
        exp_d2[ROWS/2 + i][c] = h;
      end
  endtask

  task automatic pair_check(input int a, input int b);
    int h;
    pa = PW'(a);
    pb = PW'(b);
    #1;
    h = b - a;
    check($sformatf("pair_h(%0d,%0d)", a, b), int'($signed(ph)), h);
    check($sformatf("pair_l(%0d,%0d)", a, b), int'($signed(pl)), a + floor_half(h));
  endtask

  task automatic run_transform(input string tag);
    int rise1 = 0, rise2 = 0, rise3 = 0, drops = 0;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    for (int e = 1; e <= 72; e++) begin
      @(posedge sys_clk);
      #1;
      if (d1_over_o && rise1 == 0) rise1 = e;
      else if (!d1_over_o && rise1 != 0) drops++;
      if (d2_low_over_o && rise2 == 0) rise2 = e;
      else if (!d2_low_over_o && rise2 != 0) drops++;
      if (d2_high_over_o && rise3 == 0) rise3 = e;
      else if (!d2_high_over_o && rise3 != 0) drops++;
    end
    check({tag, "_d1_edge"}, rise1, 33);
    check({tag, "_d2_low_edge"}, rise2, 49);
    check({tag, "_d2_high_edge"}, rise3, 65);
    check({tag, "_flag_drops"}, drops, 0);
    check({tag, "_state_done"}, int'(dut.state), int'(DONE));
  endtask

  task automatic check_coefs(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        check($sformatf("%s_d1[%0d][%0d]", tag, r, c), int'(dut.coef_d1[r][c]), exp_d1[r][c]);
        check($sformatf("%s_d2[%0d][%0d]", tag, r, c), int'(dut.coef_d2[r][c]), exp_d2[r][c]);
      end
  endtask

  // Restart, run k edges, then pull reset asynchronously between clock edges.
  task automatic abort_at(input int k);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (k) @(posedge sys_clk);
    #1;
    check($sformatf("pre_abort_flags_k%0d", k),
          int'({d1_over_o, d2_low_over_o, d2_high_over_o}),
          int'({k >= 33, k >= 49, k >= 65}));
    #1;
    sys_rst = 1'b0;
    #1;
    check($sformatf("abort_flags_k%0d", k),
          int'({d1_over_o, d2_low_over_o, d2_high_over_o}), 0);
    check($sformatf("abort_state_k%0d", k), int'(dut.state), int'(IDLE));
    repeat ($urandom_range(1, 4)) @(negedge sys_clk);
  endtask

  initial begin
    sys_rst = 1'b0;
    pa = '0;
    pb = '0;

    pair_check(5, 2);
    pair_check(0, 255);
    pair_check(255, 0);
    for (int n = 0; n < 16; n++)
      pair_check(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256);

    repeat (20) @(posedge sys_clk);
    #1;
    check("held_reset_flags", int'({d1_over_o, d2_low_over_o, d2_high_over_o}), 0);
    check("held_reset_state", int'(dut.state), int'(IDLE));

    build_model();
    check("model_ll00", exp_d2[0][0], 9);
    check("model_lh00", exp_d2[4][0], 16);

    run_transform("run0");
    check_coefs("run0");

    abort_at(int'($urandom_range(34, 48)));
    run_transform("run1");
    check_coefs("run1");

    abort_at(int'($urandom_range(2, 70)));
    run_transform("run2");
    check_coefs("run2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
